// File: rtl/dmem_pipe.sv
// dmem_pipe: word-addressed RAM with valid/ready port, byte enables, pipelined read, range error and zero-fill
module dmem_pipe #(
  parameter int DW = 16,
  parameter int AW = 12,
  parameter int DEPTH = 4096,
  parameter int READ_LAT = 1,
  parameter bit CLEAR_ON_RESET = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_be,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            init_done
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state;
  logic [IW-1:0] cnt;
  logic [DW-1:0] mem [DEPTH];
  logic [READ_LAT-1:0] pv, pe;
  logic [READ_LAT-1:0][DW-1:0] pd;
  logic acc, hit, clr;
  logic [IW-1:0] idx;
  assign acc = rst && req_valid && req_ready;
  assign hit = {1'b0, req_addr} < (AW+1)'(DEPTH);
  assign idx = req_addr[IW-1:0];
  assign clr = rst && state == CLEAR && CLEAR_ON_RESET;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= CLEAR;
      cnt <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else if (state == CLEAR && (!CLEAR_ON_RESET || cnt == IW'(DEPTH - 1))) begin
      state <= RUN;
      req_ready <= 1'b1;
      init_done <= 1'b1;
    end else if (state == CLEAR) begin
      cnt <= cnt + IW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (clr)
      mem[cnt] <= '0;
    else if (acc && req_wen && hit)
      for (int i = 0; i < DW / 8; i++)
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pv <= '0;
      pe <= '0;
      pd <= '0;
    end else begin
      pv[0] <= acc;
      pe[0] <= acc && !hit;
      pd[0] <= acc && !req_wen && hit ? mem[idx] : '0;
      for (int i = 1; i < READ_LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign rsp_valid = pv[READ_LAT-1];
  assign rsp_err = pe[READ_LAT-1];
  assign rsp_rdata = pd[READ_LAT-1];
endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe: directed checks of three dmem_pipe variants (latency 1/3 with zero-fill, latency 2 without)
module tb_dmem_pipe;
  logic clk = 0, rst = 0, req_valid = 0, req_wen = 0;
  logic [4:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0] req_be = '0;
  logic [2:0] rr, rv, re, id;
  logic [2:0][15:0] rd;
  int checks = 0, errors = 0;
  logic bw [4];
  logic [4:0] ba [4];
  logic [15:0] bd [4];
  logic [1:0] bb [4];
  logic [15:0] xd [4];
  logic xe [4];
  logic x2 [4];
  always #5 clk = ~clk;
  dmem_pipe #(.DW(16), .AW(5), .DEPTH(16), .READ_LAT(1), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr[0]), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv[0]),
    .rsp_rdata(rd[0]), .rsp_err(re[0]), .init_done(id[0]));
  dmem_pipe #(.DW(16), .AW(5), .DEPTH(16), .READ_LAT(3), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr[1]), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv[1]),
    .rsp_rdata(rd[1]), .rsp_err(re[1]), .init_done(id[1]));
  dmem_pipe #(.DW(16), .AW(5), .DEPTH(16), .READ_LAT(2), .CLEAR_ON_RESET(0)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr[2]), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv[2]),
    .rsp_rdata(rd[2]), .rsp_err(re[2]), .init_done(id[2]));
  function automatic int lat(int u);
    return u == 0 ? 1 : u == 1 ? 3 : 2;
  endfunction
  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic put(int i, logic w, logic [4:0] a, logic [15:0] d, logic [1:0] b,
                     logic [15:0] ed, logic ee, logic e2);
    bw[i] = w;
    ba[i] = a;
    bd[i] = d;
    bb[i] = b;
    xd[i] = ed;
    xe[i] = ee;
    x2[i] = e2;
  endtask
  task automatic drive(int k, int n);
    req_valid = k < n;
    if (k < n) begin
      req_wen = bw[k];
      req_addr = ba[k];
      req_wdata = bd[k];
      req_be = bb[k];
    end
  endtask
  task automatic burst(int n, string tag);
    int j;
    logic v;
    drive(0, n);
    for (int k = 0; k < n + 2; k++) begin
      @(posedge clk);
      #1;
      drive(k + 1, n);
      for (int u = 0; u < 3; u++) begin
        j = k - (lat(u) - 1);
        v = j >= 0 && j < n;
        check($sformatf("%s.valid u%0d k%0d", tag, u, k), rv[u], v);
        if (v) begin
          if (u != 2 || x2[j]) check($sformatf("%s.rdata u%0d k%0d", tag, u, k), rd[u], xd[j]);
          check($sformatf("%s.err u%0d k%0d", tag, u, k), re[u], xe[j]);
        end else begin
          check($sformatf("%s.idle_rdata u%0d k%0d", tag, u, k), rd[u], 0);
          check($sformatf("%s.idle_err u%0d k%0d", tag, u, k), re[u], 0);
        end
      end
    end
  endtask
  task automatic init_seq(string tag);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
        check($sformatf("%s.init_done u%0d k%0d", tag, u, k), id[u], k == 16);
        check($sformatf("%s.ready u%0d k%0d", tag, u, k), rr[u], k == 16);
      end
      check($sformatf("%s.init_done u2 k%0d", tag, k), id[2], 1);
      check($sformatf("%s.ready u2 k%0d", tag, k), rr[2], 1);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("rst.ready u%0d", u), rr[u], 0);
      check($sformatf("rst.valid u%0d", u), rv[u], 0);
      check($sformatf("rst.rdata u%0d", u), rd[u], 0);
      check($sformatf("rst.err u%0d", u), re[u], 0);
      check($sformatf("rst.init_done u%0d", u), id[u], 0);
    end
    rst = 1;
    init_seq("init");
    for (int a = 0; a < 16; a += 4) begin
      for (int i = 0; i < 4; i++) put(i, 0, 5'(a + i), 0, 0, 0, 0, 0);
      burst(4, "zero");
    end
    put(0, 1, 5, 16'h1234, 2'b11, 0, 0, 1);
    put(1, 1, 5, 16'hABCD, 2'b01, 0, 0, 1);
    put(2, 0, 5, 0, 0, 16'h12CD, 0, 1);
    burst(3, "be");
    put(0, 1, 5, 16'hFFFF, 2'b00, 0, 0, 1);
    put(1, 0, 5, 0, 0, 16'h12CD, 0, 1);
    burst(2, "be0");
    put(0, 0, 20, 0, 0, 0, 1, 1);
    put(1, 1, 20, 16'hFFFF, 2'b11, 0, 1, 1);
    put(2, 0, 16, 0, 0, 0, 1, 1);
    put(3, 1, 31, 16'hFFFF, 2'b11, 0, 1, 1);
    burst(4, "oor");
    for (int a = 0; a < 16; a += 4) begin
      for (int i = 0; i < 4; i++) put(i, 0, 5'(a + i), 0, 0, (a + i) == 5 ? 16'h12CD : 16'h0, 0, (a + i) == 5);
      burst(4, "oor_keep");
    end
    put(0, 1, 1, 16'h0011, 2'b11, 0, 0, 1);
    put(1, 1, 2, 16'h0022, 2'b11, 0, 0, 1);
    put(2, 1, 3, 16'h0033, 2'b11, 0, 0, 1);
    burst(3, "wr123");
    put(0, 0, 1, 0, 0, 16'h0011, 0, 1);
    put(1, 0, 2, 0, 0, 16'h0022, 0, 1);
    put(2, 0, 3, 0, 0, 16'h0033, 0, 1);
    burst(3, "order");
    put(0, 1, 7, 16'hBEEF, 2'b11, 0, 0, 1);
    put(1, 0, 7, 0, 0, 16'hBEEF, 0, 1);
    burst(2, "raw");
    req_valid = 1;
    req_wen = 0;
    req_addr = 5;
    @(posedge clk);
    #1;
    req_valid = 0;
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++) begin
        check($sformatf("midrst.valid u%0d k%0d", u, k), rv[u], 0);
        check($sformatf("midrst.init_done u%0d k%0d", u, k), id[u], 0);
      end
    end
    rst = 1;
    init_seq("reinit");
    put(0, 0, 5, 0, 0, 0, 0, 0);
    put(1, 0, 7, 0, 0, 0, 0, 0);
    burst(2, "recleared");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
